wimax_frame_ctrl: RTL and testbench

Frame-level sequencer for the WiMax transmit chain (PRBS randomizer → FEC → interleaver → QPSK modulator). Runs on clk_100 and generates a 50 MHz clock-enable for the bit-rate side of the chain. Each frame it pulses the randomizer seed load, then streams exactly one 96-bit block from an upstream bit source into the chain. It waits for the modulator to emit the matching 96 symbols, counts completed frames and flags underrun and timeout errors.

---
 rtl/wimax_frame_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_wimax_frame_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wimax_frame_ctrl.sv
// Frame sequencer for the WiMax TX chain: seed load, one 96-bit block stream,
// then a symbol drain guarded by a timeout. Bit-rate side runs on the ce_50 enable.
module wimax_frame_ctrl #(
    parameter int BLOCK_BITS = 96,
    parameter int SYMBOLS    = 96,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk_100,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        clr_err_i,
    input  logic        src_valid_i,
    input  logic        src_data_i,
    output logic        src_ready_o,
    input  logic        dn_ready_i,
    input  logic        mod_valid_i,
    output logic        ce_50_o,
    output logic        phy_load_o,
    output logic        phy_enable_o,
    output logic        phy_data_o,
    output logic        phy_valid_in_o,
    output logic        phy_ready_in_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic [15:0] frame_cnt_o,
    output logic        err_underrun_o,
    output logic        err_timeout_o
);
    // state  | meaning
    // IDLE   | waiting for start on a ce_50 edge
    // LOAD   | randomizer seed load for one ce_50 period, counters cleared
    // STREAM | moving BLOCK_BITS source bits into the chain
    // DRAIN  | waiting for SYMBOLS modulator symbols, timeout running
    // DONE   | frame completed, pulse frame_done
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int BW = $clog2(BLOCK_BITS + 1);
    localparam int SW = $clog2(SYMBOLS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(BLOCK_BITS - 1);
    localparam logic [SW-1:0] SYM_FULL = SW'(SYMBOLS);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic          ce_q;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [SW-1:0] sym_cnt_q, sym_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          load_q, load_d;
    logic          en_q, en_d;
    logic          data_q, data_d;
    logic          done_q, done_d;
    logic          busy_q;
    logic          rdy_q;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          und_q, tmo_q;
    logic          und_set, tmo_set;
    logic          in_stream, accept;

    assign in_stream = (state_q == S_STREAM);
    assign accept    = in_stream & ce_q & dn_ready_i & src_valid_i;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sym_cnt_d   = sym_cnt_q;
        to_cnt_d    = to_cnt_q;
        load_d      = load_q;
        en_d        = en_q;
        data_d      = data_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        und_set     = 1'b0;
        tmo_set     = 1'b0;

        if ((in_stream || state_q == S_DRAIN) && ce_q && mod_valid_i && sym_cnt_q != SYM_FULL)
            sym_cnt_d = sym_cnt_q + SW'(1);

        case (state_q)
            S_IDLE: begin
                if (ce_q && start_i) begin
                    state_d = S_LOAD;
                    load_d  = 1'b1;
                end
            end
            S_LOAD: begin
                bit_cnt_d = '0;
                sym_cnt_d = '0;
                to_cnt_d  = '0;
                if (ce_q) begin
                    state_d = S_STREAM;
                    load_d  = 1'b0;
                    en_d    = 1'b0;
                end
            end
            S_STREAM: begin
                if (ce_q) begin
                    en_d = accept;
                    if (accept) begin
                        data_d    = src_data_i;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == LAST_BIT)
                            state_d = S_DRAIN;
                    end else if (dn_ready_i) begin
                        und_set = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (ce_q)
                    en_d = 1'b0;
                to_cnt_d = to_cnt_q + TW'(1);
                if (sym_cnt_q == SYM_FULL) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = S_IDLE;
                    tmo_set = 1'b1;
                end
            end
            S_DONE: begin
                if (ce_q) begin
                    en_d = 1'b0;
                    if (start_i) begin
                        state_d = S_LOAD;
                        load_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ce_q        <= 1'b0;
            bit_cnt_q   <= '0;
            sym_cnt_q   <= '0;
            to_cnt_q    <= '0;
            load_q      <= 1'b0;
            en_q        <= 1'b0;
            data_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            rdy_q       <= 1'b0;
            frame_cnt_q <= '0;
            und_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ce_q        <= ~ce_q;
            bit_cnt_q   <= bit_cnt_d;
            sym_cnt_q   <= sym_cnt_d;
            to_cnt_q    <= to_cnt_d;
            load_q      <= load_d;
            en_q        <= en_d;
            data_q      <= data_d;
            done_q      <= done_d;
            busy_q      <= (state_d != S_IDLE);
            rdy_q       <= dn_ready_i;
            frame_cnt_q <= frame_cnt_d;
            // a set in the same cycle as clr_err takes priority
            und_q       <= und_set | (und_q & ~clr_err_i);
            tmo_q       <= tmo_set | (tmo_q & ~clr_err_i);
        end
    end

    assign src_ready_o    = in_stream & ce_q & dn_ready_i;
    assign ce_50_o        = ce_q;
    assign phy_load_o     = load_q;
    assign phy_enable_o   = en_q;
    assign phy_data_o     = data_q;
    assign phy_valid_in_o = en_q;
    assign phy_ready_in_o = rdy_q;
    assign busy_o         = busy_q;
    assign frame_done_o   = done_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign err_underrun_o = und_q;
    assign err_timeout_o  = tmo_q;
endmodule

// File: tb/tb_wimax_frame_ctrl.sv
// Directed bench for wimax_frame_ctrl: bit source, capture monitor and symbol driver.
module tb_wimax_frame_ctrl;
    logic        clk_100 = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        clr_err_i = 1'b0;
    logic        src_valid_i = 1'b0;
    logic        dn_ready_i = 1'b0;
    logic        mod_valid_i = 1'b0;
    logic        src_data_i;
    logic        src_ready_o, ce_50_o, phy_load_o, phy_enable_o, phy_data_o;
    logic        phy_valid_in_o, phy_ready_in_o, busy_o, frame_done_o;
    logic        err_underrun_o, err_timeout_o;
    logic [15:0] frame_cnt_o;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int cap_cnt = 0;
    int done_cnt = 0;
    logic [95:0] blk = '0;
    logic [95:0] cap = '0;
    logic [6:0]  idx;
    logic [6:0]  sel;

    wimax_frame_ctrl dut (
        .clk_100(clk_100), .rst_n(rst_n), .start_i(start_i), .clr_err_i(clr_err_i),
        .src_valid_i(src_valid_i), .src_data_i(src_data_i), .src_ready_o(src_ready_o),
        .dn_ready_i(dn_ready_i), .mod_valid_i(mod_valid_i), .ce_50_o(ce_50_o),
        .phy_load_o(phy_load_o), .phy_enable_o(phy_enable_o), .phy_data_o(phy_data_o),
        .phy_valid_in_o(phy_valid_in_o), .phy_ready_in_o(phy_ready_in_o), .busy_o(busy_o),
        .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o),
        .err_underrun_o(err_underrun_o), .err_timeout_o(err_timeout_o)
    );

    always #5 clk_100 = ~clk_100;

    // upstream source: presents blk MSB-first, advancing on each accepted bit
    assign sel = 7'd95 - idx;
    assign src_data_i = (idx < 7'd96) ? blk[sel] : 1'b0;

    always @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) idx <= '0;
        else if (phy_load_o) idx <= '0;
        else if (src_ready_o && src_valid_i && idx < 7'd96) idx <= idx + 7'd1;
    end

    always @(negedge clk_100) begin
        if (phy_enable_o && !ce_50_o) begin
            cap     <= {cap[94:0], phy_data_o};
            cap_cnt <= cap_cnt + 1;
        end
        if (frame_done_o) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_load(output bit ok);
        int n = 0;
        while (!phy_load_o && n < 100) begin @(negedge clk_100); n++; end
        ok = phy_load_o;
    endtask

    task automatic start_frame(output bit ok);
        wait_load(ok);
        @(negedge clk_100);
    endtask

    task automatic wait_idx(input int target, output bit ok);
        int n = 0;
        while (int'(idx) < target && n < 1000) begin @(negedge clk_100); n++; end
        ok = (int'(idx) >= target);
    endtask

    task automatic drain(input int nsym, output int k);
        k = 0;
        while (busy_o && !frame_done_o && k < 1300) begin
            mod_valid_i = (k < 2 * nsym);
            @(negedge clk_100);
            k++;
        end
        mod_valid_i = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy_o && n < 20) begin @(negedge clk_100); n++; end
        ok = !busy_o;
    endtask

    task automatic test_reset;
        logic [11:0] outs;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_100);
        outs = {src_ready_o, ce_50_o, phy_load_o, phy_enable_o, phy_data_o, phy_valid_in_o,
                phy_ready_in_o, busy_o, frame_done_o, err_underrun_o, err_timeout_o, |frame_cnt_o};
        checks++; if (outs !== 12'h000) begin errors++; $display("FAIL reset_outputs: got %b required 0", outs); end
        rst_n = 1'b1;
        #1;
        checks++; if (ce_50_o !== 1'b0) begin errors++; $display("FAIL ce_first_cycle: got %b required 0", ce_50_o); end
        @(negedge clk_100);
        checks++; if (ce_50_o !== 1'b1) begin errors++; $display("FAIL ce_second_cycle: got %b required 1", ce_50_o); end
        @(negedge clk_100);
        checks++; if (ce_50_o !== 1'b0) begin errors++; $display("FAIL ce_third_cycle: got %b required 0", ce_50_o); end
    endtask

    task automatic test_basic;
        bit ok; int n; int m; int k; int c0; int d0;
        blk = 96'hACBCD2114DAE1577C6DBF4C9;
        c0 = cap_cnt; d0 = done_cnt;
        src_valid_i = 1'b1; dn_ready_i = 1'b1; start_i = 1'b1;
        wait_load(ok);
        start_i = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL basic_load_seen: got %b required 1", phy_load_o); end
        n = 0;
        while (phy_load_o && n < 10) begin @(negedge clk_100); n++; end
        checks++; if (n !== 2) begin errors++; $display("FAIL basic_load_width: got %0d cycles required 2", n); end
        m = 0;
        while (!phy_enable_o && m < 10) begin @(negedge clk_100); m++; end
        checks++; if (m !== 2) begin errors++; $display("FAIL basic_enable_gap: got %0d cycles required 2", m); end
        wait_idx(96, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_stream_timeout: idx %0d required 96", idx); end
        drain(96, k);
        checks++; if (frame_done_o !== 1'b1) begin errors++; $display("FAIL basic_done_seen: got %b required 1 after %0d cycles", frame_done_o, k); end
        wait_idle(ok);
        exp_cnt = 1;
        checks++; if (!ok) begin errors++; $display("FAIL basic_idle: busy %b required 0", busy_o); end
        checks++; if (cap_cnt - c0 !== 96) begin errors++; $display("FAIL basic_bit_count: got %0d required 96", cap_cnt - c0); end
        checks++; if (cap !== blk) begin errors++; $display("FAIL basic_data: got %h required %h", cap, blk); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d required 1", done_cnt - d0); end
        checks++; if (frame_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL basic_frame_cnt: got %0d required %0d", frame_cnt_o, exp_cnt); end
        checks++; if ({err_underrun_o, err_timeout_o} !== 2'b00) begin errors++; $display("FAIL basic_no_err: got %b required 00", {err_underrun_o, err_timeout_o}); end
    endtask

    task automatic test_underrun;
        bit ok; int k; int c0;
        blk = 96'h0123456789ABCDEF0F1E2D3C;
        c0 = cap_cnt;
        start_i = 1'b1;
        start_frame(ok);
        start_i = 1'b0;
        wait_idx(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL und_reach40: idx %0d required 40", idx); end
        src_valid_i = 1'b0;
        repeat (6) @(negedge clk_100);
        checks++; if (err_underrun_o !== 1'b1) begin errors++; $display("FAIL und_flag: got %b required 1", err_underrun_o); end
        checks++; if (dut.bit_cnt_q !== 7'd40) begin errors++; $display("FAIL und_bit_hold: got %0d required 40", dut.bit_cnt_q); end
        checks++; if (phy_enable_o !== 1'b0) begin errors++; $display("FAIL und_enable_low: got %b required 0", phy_enable_o); end
        src_valid_i = 1'b1;
        wait_idx(96, ok);
        drain(96, k);
        wait_idle(ok);
        exp_cnt = 2;
        checks++; if (cap_cnt - c0 !== 96 || cap !== blk) begin errors++; $display("FAIL und_data: got %0d bits %h required 96 bits %h", cap_cnt - c0, cap, blk); end
        checks++; if (frame_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL und_frame_cnt: got %0d required %0d", frame_cnt_o, exp_cnt); end
        checks++; if (err_underrun_o !== 1'b1) begin errors++; $display("FAIL und_sticky: got %b required 1", err_underrun_o); end
        clr_err_i = 1'b1;
        @(negedge clk_100);
        clr_err_i = 1'b0;
        checks++; if (err_underrun_o !== 1'b0) begin errors++; $display("FAIL und_clear: got %b required 0", err_underrun_o); end
    endtask

    task automatic test_dn_stall;
        bit ok; int k; int c0; int bad_rdy; int bad_en;
        blk = 96'hF00DCAFE123456789ABCDEF0;
        c0 = cap_cnt; bad_rdy = 0; bad_en = 0;
        start_i = 1'b1;
        start_frame(ok);
        start_i = 1'b0;
        wait_idx(50, ok);
        dn_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_100);
            if (src_ready_o) bad_rdy++;
            if (i >= 1 && phy_enable_o) bad_en++;
        end
        checks++; if (bad_rdy !== 0) begin errors++; $display("FAIL dn_src_ready: got %0d high samples required 0", bad_rdy); end
        checks++; if (bad_en !== 0) begin errors++; $display("FAIL dn_enable: got %0d high samples required 0", bad_en); end
        checks++; if (phy_ready_in_o !== 1'b0) begin errors++; $display("FAIL dn_ready_in: got %b required 0", phy_ready_in_o); end
        checks++; if (dut.bit_cnt_q !== 7'd50) begin errors++; $display("FAIL dn_bit_hold: got %0d required 50", dut.bit_cnt_q); end
        checks++; if (err_underrun_o !== 1'b0) begin errors++; $display("FAIL dn_no_underrun: got %b required 0", err_underrun_o); end
        dn_ready_i = 1'b1;
        wait_idx(96, ok);
        drain(96, k);
        wait_idle(ok);
        exp_cnt = 3;
        checks++; if (cap_cnt - c0 !== 96 || cap !== blk) begin errors++; $display("FAIL dn_data: got %0d bits %h required 96 bits %h", cap_cnt - c0, cap, blk); end
        checks++; if (frame_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL dn_frame_cnt: got %0d required %0d", frame_cnt_o, exp_cnt); end
    endtask

    task automatic test_timeout;
        bit ok; int k; int d0;
        blk = 96'h5555AAAA5555AAAA5555AAAA;
        d0 = done_cnt;
        start_i = 1'b1;
        start_frame(ok);
        start_i = 1'b0;
        wait_idx(96, ok);
        drain(95, k);
        checks++; if (k !== 1024) begin errors++; $display("FAIL tmo_drain_len: got %0d cycles required 1024", k); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL tmo_idle: busy %b required 0", busy_o); end
        checks++; if (err_timeout_o !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b required 1", err_timeout_o); end
        checks++; if (frame_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL tmo_frame_cnt: got %0d required %0d", frame_cnt_o, exp_cnt); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL tmo_no_done: got %0d pulses required 0", done_cnt - d0); end
        clr_err_i = 1'b1;
        @(negedge clk_100);
        clr_err_i = 1'b0;
        checks++; if (err_timeout_o !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b required 0", err_timeout_o); end
    endtask

    task automatic test_wrap;
        bit ok; int k;
        blk = 96'h13579BDF2468ACE013579BDF;
        @(negedge clk_100);
        force dut.frame_cnt_q = 16'hFFFF;
        start_i = 1'b1;
        start_frame(ok);
        start_i = 1'b0;
        wait_idx(96, ok);
        release dut.frame_cnt_q;
        drain(96, k);
        wait_idle(ok);
        exp_cnt = 0;
        checks++; if (frame_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL wrap_frame_cnt: got %h required 0000", frame_cnt_o); end
    endtask

    task automatic test_back_to_back;
        bit ok; int k; int d0; int lost;
        blk = 96'hDEADBEEF0BADF00D8BADCAFE;
        d0 = done_cnt; lost = 0;
        start_i = 1'b1;
        for (int f = 0; f < 3; f++) begin
            start_frame(ok);
            if (!ok) lost++;
            if (f == 2) begin
                wait_idx(20, ok);
                start_i = 1'b0;
            end
            wait_idx(96, ok);
            drain(96, k);
            if (!frame_done_o) lost++;
            if (f < 2 && !busy_o) lost++;
        end
        wait_idle(ok);
        exp_cnt = 3;
        checks++; if (lost !== 0) begin errors++; $display("FAIL b2b_sequence: got %0d missed events required 0", lost); end
        checks++; if (frame_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL b2b_frame_cnt: got %0d required %0d", frame_cnt_o, exp_cnt); end
        checks++; if (done_cnt - d0 !== 3) begin errors++; $display("FAIL b2b_done_pulses: got %0d required 3", done_cnt - d0); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy %b required 0", busy_o); end
        checks++; if (cap !== blk) begin errors++; $display("FAIL b2b_data: got %h required %h", cap, blk); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        logic [11:0] outs;
        blk = 96'hFFFFFFFFFFFFFFFFFFFFFFFF;
        start_i = 1'b1;
        start_frame(ok);
        start_i = 1'b0;
        wait_idx(30, ok);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b required 1", busy_o); end
        rst_n = 1'b0;
        #1;
        outs = {src_ready_o, ce_50_o, phy_load_o, phy_enable_o, phy_data_o, phy_valid_in_o,
                phy_ready_in_o, busy_o, frame_done_o, err_underrun_o, err_timeout_o, |frame_cnt_o};
        checks++; if (outs !== 12'h000) begin errors++; $display("FAIL rst_mid_outputs: got %b required 0", outs); end
        checks++; if (dut.bit_cnt_q !== 7'd0 || dut.state_q !== 3'd0) begin errors++; $display("FAIL rst_mid_state: bit_cnt %0d state %0d required 0 0", dut.bit_cnt_q, dut.state_q); end
        @(negedge clk_100);
        rst_n = 1'b1;
        repeat (6) @(negedge clk_100);
        checks++; if (busy_o !== 1'b0 || frame_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_mid_after: busy %b cnt %0d required 0 0", busy_o, frame_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_dn_stall();
        test_timeout();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
